// File: rtl/gpr_dump.sv
// Debug read-out engine: walks register-file addresses and streams each value out on valid/ready.
// Optional checksum beat after the last register is enabled with GPR_DUMP_CHECKSUM_EN.
module gpr_dump #(
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FIRST_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StSend,
        StCsum,
        StDone
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
`ifdef GPR_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= FirstIdx;
            busy         <= 1'b0;
            done         <= 1'b0;
            rf_read_addr <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_index    <= '0;
            out_last     <= 1'b0;
`ifdef GPR_DUMP_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StAddr;
                        idx_q        <= FirstIdx;
                        rf_read_addr <= FirstIdx;
                        busy         <= 1'b1;
`ifdef GPR_DUMP_CHECKSUM_EN
                        sum_q        <= '0;
`endif
                    end
                end
                StAddr: begin
                    // Read data is combinational, so it is captured on the edge leaving StAddr.
                    out_data  <= rf_read_data;
                    out_index <= idx_q;
                    out_valid <= 1'b1;
                    state_q   <= StSend;
`ifdef GPR_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
                    sum_q     <= sum_q + rf_read_data;
`else
                    out_last  <= (idx_q == LastIdx);
`endif
                end
                StSend: begin
                    if (out_ready) begin
                        if (idx_q == LastIdx) begin
`ifdef GPR_DUMP_CHECKSUM_EN
                            // Keep valid high and swap in the checksum beat.
                            out_data  <= sum_q;
                            out_index <= '0;
                            out_last  <= 1'b1;
                            state_q   <= StCsum;
`else
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state_q   <= StDone;
`endif
                        end else begin
                            out_valid    <= 1'b0;
                            idx_q        <= idx_q + ADDR_W'(1);
                            rf_read_addr <= idx_q + ADDR_W'(1);
                            state_q      <= StAddr;
                        end
                    end
                end
                StCsum: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gpr_dump.sv
// Randomized self-checking bench for gpr_dump against a queue-based model of the expected beats.
module tb_gpr_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start1;
    logic        busy, busy1, done, done1;
    logic [2:0]  rf_read_addr, rf_read_addr1;
    logic [15:0] rf_read_data, rf_read_data1;
    logic        out_valid, out_valid1, out_ready, out_ready1;
    logic [15:0] out_data, out_data1;
    logic [2:0]  out_index, out_index1;
    logic        out_last, out_last1;

    logic [15:0] rf [8];

    always #5 clk = ~clk;

    assign rf_read_data  = rf[rf_read_addr];
    assign rf_read_data1 = rf[rf_read_addr1];

    gpr_dump #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(16), .FIRST_REG(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last)
    );

    gpr_dump #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(16), .FIRST_REG(7)) dut_last (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .rf_read_addr(rf_read_addr1), .rf_read_data(rf_read_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_index(out_index1), .out_last(out_last1)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [19:0] exp_beats[$];
    logic [19:0] obs_beats[$];
    int done_cnt, done_cycle, first_valid_cycle, unstable, busy_gap, timed_out;
    bit busy_hist [0:63];

    // Expected beats as {data, index, last}, from the current register contents.
    function automatic void build_expected(input int first);
        logic [15:0] s;
        s = 16'h0;
        exp_beats.delete();
        for (int i = first; i < 8; i++) begin
`ifdef GPR_DUMP_CHECKSUM_EN
            exp_beats.push_back({rf[i], 3'(i), 1'b0});
`else
            exp_beats.push_back({rf[i], 3'(i), (i == 7) ? 1'b1 : 1'b0});
`endif
            s = s + rf[i];
        end
`ifdef GPR_DUMP_CHECKSUM_EN
        exp_beats.push_back({s, 3'd0, 1'b1});
`endif
    endfunction

    // Cycle (counted from the start-sampling edge) in which done is high, ready tied high.
    function automatic int exp_done_cycle(input int first);
`ifdef GPR_DUMP_CHECKSUM_EN
        return 2 * (8 - first) + 2;
`else
        return 2 * (8 - first) + 1;
`endif
    endfunction

    // Drives one dump on dut and records what it produced; mode 0 ready=1, 1 random, 2 stall.
    task automatic run_dump(input int ready_mode, input int stall_index, input int stall_len,
                            input int restart_index, input bit hold_start, input int budget);
        int          c = 0;
        int          stall_left = stall_len;
        bit          prev_hold = 1'b0;
        logic [19:0] prev_beat = '0;
        obs_beats.delete();
        done_cnt = 0; done_cycle = -1; first_valid_cycle = -1;
        unstable = 0; busy_gap = 0; timed_out = 0;
        for (int i = 0; i < 64; i++) busy_hist[i] = 1'b0;
        @(negedge clk);
        start = 1'b1;
        out_ready = (ready_mode == 0);
        @(posedge clk);
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        while (1) begin
            c++;
            if (c < 64) busy_hist[c] = busy;
            if (prev_hold && !(out_valid && {out_data, out_index, out_last} == prev_beat))
                unstable++;
            if (out_valid && first_valid_cycle < 0) first_valid_cycle = c;
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (done_cycle < 0 && !busy) busy_gap++;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && out_index == 3'(stall_index) && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            // Already-captured register changes; the pending beat must not follow it.
            if (ready_mode == 1 && out_valid && !out_ready) rf[out_index] = 16'($urandom);
            start = hold_start | (restart_index >= 0 && out_valid && out_index == 3'(restart_index));
            if (out_valid && out_ready) obs_beats.push_back({out_data, out_index, out_last});
            prev_hold = out_valid && !out_ready;
            prev_beat = {out_data, out_index, out_last};
            if (done_cycle >= 0 && c >= done_cycle + 3) break;
            if (c >= budget) begin
                timed_out = 1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic load_plan_values();
        rf[0] = 16'h0000; rf[1] = 16'h0000; rf[2] = 16'h0003; rf[3] = 16'h0003;
        rf[4] = 16'h00AA; rf[5] = 16'h1234; rf[6] = 16'hFFFF; rf[7] = 16'h8000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, out_valid, out_last} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, out_valid, out_last});
        end
        vectors++;
        if ({out_data, out_index, rf_read_addr} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", {out_data, out_index, rf_read_addr});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        load_plan_values();
        build_expected(0);
        run_dump(0, -1, 0, -1, 1'b0, 200);
        vectors++;
        if (timed_out != 0) begin
            miscompares++; $display("FAIL basic_timeout: got %0d want 0", timed_out);
        end
        vectors++;
        if (obs_beats.size() != exp_beats.size()) begin
            miscompares++;
            $display("FAIL basic_count: got %0d want %0d", obs_beats.size(), exp_beats.size());
        end
        for (int i = 0; i < obs_beats.size() && i < exp_beats.size(); i++) begin
            vectors++;
            if (obs_beats[i] !== exp_beats[i]) begin
                miscompares++;
                $display("FAIL basic_beat%0d: got %h want %h", i, obs_beats[i], exp_beats[i]);
            end
        end
        vectors++;
        if (done_cnt != 1 || done_cycle != exp_done_cycle(0)) begin
            miscompares++;
            $display("FAIL basic_done: got cnt %0d cyc %0d want 1 %0d", done_cnt, done_cycle,
                     exp_done_cycle(0));
        end
        vectors++;
        if (first_valid_cycle != 2) begin
            miscompares++; $display("FAIL basic_latency: got %0d want 2", first_valid_cycle);
        end
        vectors++;
        if (busy_gap != 0 || done_cycle < 0 || busy_hist[done_cycle + 1] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy: got gap %0d want 0 and idle after done", busy_gap);
        end
    endtask

    task automatic test_backpressure();
        load_plan_values();
        build_expected(0);
        run_dump(2, 2, 5, -1, 1'b0, 200);
        vectors++;
        if (unstable != 0) begin
            miscompares++; $display("FAIL bp_stable: got %0d changes want 0", unstable);
        end
        vectors++;
        if (obs_beats.size() != exp_beats.size()) begin
            miscompares++;
            $display("FAIL bp_count: got %0d want %0d", obs_beats.size(), exp_beats.size());
        end
        for (int i = 0; i < obs_beats.size() && i < exp_beats.size(); i++) begin
            vectors++;
            if (obs_beats[i] !== exp_beats[i]) begin
                miscompares++;
                $display("FAIL bp_beat%0d: got %h want %h", i, obs_beats[i], exp_beats[i]);
            end
        end
        vectors++;
        if (done_cycle != exp_done_cycle(0) + 5) begin
            miscompares++;
            $display("FAIL bp_done: got %0d want %0d", done_cycle, exp_done_cycle(0) + 5);
        end
    endtask

    task automatic test_back_to_back_start();
        load_plan_values();
        build_expected(0);
        run_dump(0, -1, 0, 4, 1'b0, 200);
        vectors++;
        if (obs_beats.size() != exp_beats.size() || done_cnt != 1) begin
            miscompares++;
            $display("FAIL restart_ignored: got %0d beats %0d done want %0d 1",
                     obs_beats.size(), done_cnt, exp_beats.size());
        end
        for (int i = 0; i < obs_beats.size() && i < exp_beats.size(); i++) begin
            vectors++;
            if (obs_beats[i] !== exp_beats[i]) begin
                miscompares++;
                $display("FAIL restart_beat%0d: got %h want %h", i, obs_beats[i], exp_beats[i]);
            end
        end
    endtask

    task automatic test_start_held();
        load_plan_values();
        run_dump(0, -1, 0, -1, 1'b1, 200);
        vectors++;
        if (done_cycle != exp_done_cycle(0) || busy_hist[done_cycle + 1] !== 1'b0 ||
            busy_hist[done_cycle + 2] !== 1'b1) begin
            miscompares++;
            $display("FAIL held_retrigger: got done %0d busy %b%b want %0d 01", done_cycle,
                     busy_hist[done_cycle + 1], busy_hist[done_cycle + 2], exp_done_cycle(0));
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int late_done = 0;
        load_plan_values();
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(out_valid && out_index == 3'd5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 100) begin
            miscompares++; $display("FAIL rstmid_reach: got timeout want index 5 beat");
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, busy, done, out_index} !== 6'b0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got %b want 000000", {out_valid, busy, done, out_index});
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) late_done++;
            @(negedge clk);
        end
        vectors++;
        if (late_done != 0) begin
            miscompares++; $display("FAIL rstmid_nodone: got %0d want 0", late_done);
        end
        build_expected(0);
        run_dump(0, -1, 0, -1, 1'b0, 200);
        vectors++;
        if (obs_beats.size() != exp_beats.size() || obs_beats[0] !== exp_beats[0]) begin
            miscompares++;
            $display("FAIL rstmid_restart: got %0d beats first %h want %0d %h",
                     obs_beats.size(), obs_beats[0], exp_beats.size(), exp_beats[0]);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
            build_expected(0);
            run_dump(1, -1, 0, -1, 1'b0, 600);
            vectors++;
            if (timed_out != 0 || done_cnt != 1 || unstable != 0) begin
                miscompares++;
                $display("FAIL rand%0d_ctrl: got to %0d done %0d unstable %0d want 0 1 0", t,
                         timed_out, done_cnt, unstable);
            end
            vectors++;
            if (obs_beats.size() != exp_beats.size()) begin
                miscompares++;
                $display("FAIL rand%0d_count: got %0d want %0d", t, obs_beats.size(),
                         exp_beats.size());
            end
            for (int i = 0; i < obs_beats.size() && i < exp_beats.size(); i++) begin
                vectors++;
                if (obs_beats[i] !== exp_beats[i]) begin
                    miscompares++;
                    $display("FAIL rand%0d_beat%0d: got %h want %h", t, i, obs_beats[i],
                             exp_beats[i]);
                end
            end
        end
    endtask

    task automatic test_first_last();
        logic [19:0] got[$];
        int          c = 0;
        int          dcyc = -1;
        load_plan_values();
        build_expected(7);
        @(negedge clk);
        start1 = 1'b1;
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        while (c < 20) begin
            c++;
            if (out_valid1 && out_ready1) got.push_back({out_data1, out_index1, out_last1});
            if (done1 && dcyc < 0) dcyc = c;
            @(negedge clk);
        end
        vectors++;
        if (got.size() != exp_beats.size()) begin
            miscompares++;
            $display("FAIL first7_count: got %0d want %0d", got.size(), exp_beats.size());
        end
        for (int i = 0; i < got.size() && i < exp_beats.size(); i++) begin
            vectors++;
            if (got[i] !== exp_beats[i]) begin
                miscompares++;
                $display("FAIL first7_beat%0d: got %h want %h", i, got[i], exp_beats[i]);
            end
        end
        vectors++;
        if (dcyc != exp_done_cycle(7)) begin
            miscompares++; $display("FAIL first7_done: got %0d want %0d", dcyc, exp_done_cycle(7));
        end
        out_ready1 = 1'b0;
    endtask

    initial begin
        start = 1'b0;
        start1 = 1'b0;
        out_ready = 1'b0;
        out_ready1 = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back_start();
        test_start_held();
        test_reset_mid();
        test_random();
        test_first_last();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
